// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the writeback port arbiter: default widths, the
// hard-wired zero register and the requester identities.
package wb_port_arbiter_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int REG_ZERO  = 0;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_t;

endpackage

// File: rtl/mux2.sv
// Generic 2:1 mux; pure combinational, no latency, no flow control.
module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/wb_port_arbiter_rr_arb2.sv
// Two-way round-robin grant with its priority flop; grants are combinational,
// none is issued while can_accept is low, and priority moves only on a grant.
module rr_arb2
  import wb_port_arbiter_pkg::*;
#(
  parameter int PRIO_RESET = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic can_accept,
  output logic grant0,
  output logic grant1
);

  localparam req_id_t PRIO_INIT = (PRIO_RESET != 0) ? REQ_LOAD : REQ_ALU;

  req_id_t prio;

  always_comb begin
    grant0 = can_accept & valid0 & (~valid1 | (prio == REQ_ALU));
    grant1 = can_accept & valid1 & (~valid0 | (prio == REQ_LOAD));
  end

  // A grant is always an accept, so the loser of this cycle goes first next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PRIO_INIT;
    end else if (grant0) begin
      prio <= REQ_LOAD;
    end else if (grant1) begin
      prio <= REQ_ALU;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates ALU and load writebacks onto the register-file write port; 1-cycle
// accept-to-wr_en latency; readies drop while a held write is not consumed.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int PRIO_RESET = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              zero_drop
);

  logic              can_accept;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              to_zero;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Accepting while the held write drains keeps the port busy every cycle.
  assign can_accept = ~wr_en | wr_ready;

  rr_arb2 #(
    .PRIO_RESET(PRIO_RESET)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .can_accept(can_accept),
    .grant0    (grant0),
    .grant1    (grant1)
  );

  mux2 #(.W(ADDR_W)) u_addr_mux (.d0(req0_addr), .d1(req1_addr), .sel(grant1), .y(sel_addr));
  mux2 #(.W(DATA_W)) u_data_mux (.d0(req0_data), .d1(req1_data), .sel(grant1), .y(sel_data));

  assign req0_ready = rst_n & grant0;
  assign req1_ready = rst_n & grant1;
  assign accept     = grant0 | grant1;
  assign to_zero    = (sel_addr == ADDR_W'(REG_ZERO));

  // Writes to the zero register are consumed but never reach the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      zero_drop <= 1'b0;
    end else begin
      zero_drop <= accept & to_zero;
      if (accept && !to_zero) begin
        wr_en   <= 1'b1;
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end else if (wr_ready) begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a behavioural model.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr, wr_addr;
  logic [31:0] req0_data, req1_data, wr_data;
  logic        wr_en, wr_ready, zero_drop;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .PRIO_RESET(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .zero_drop(zero_drop)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: the pending register-file write, the drop pulse, whose turn it is.
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_zero;
  int          m_turn;
  int          last_win;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_addr = '0; m_data = '0; m_zero = 1'b0; m_turn = 0; last_win = -1;
  endtask

  // One clock: drive, check readies, clock, update model, check registered outputs.
  task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic wrr);
    int          win;
    logic [4:0]  wa;
    logic [31:0] wd;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    wr_ready   = wrr;
    #1;
    win = -1;
    if (!m_en || wrr) begin
      if (v0 && v1)  win = m_turn;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
    end
    check_eq("req0_ready", req0_ready, win == 0);
    check_eq("req1_ready", req1_ready, win == 1);
    last_win = win;
    @(posedge clk);
    wa = (win == 1) ? a1 : a0;
    wd = (win == 1) ? d1 : d0;
    if (m_en && wrr) m_en = 1'b0;
    m_zero = (win >= 0) && (wa == 5'd0);
    if (win >= 0) begin
      m_turn = 1 - win;
      if (wa != 5'd0) begin
        m_en = 1'b1; m_addr = wa; m_data = wd;
      end
    end
    #1;
    check_eq("wr_en", wr_en, m_en);
    check_eq("wr_addr", wr_addr, m_addr);
    check_eq("wr_data", wr_data, m_data);
    check_eq("zero_drop", zero_drop, m_zero);
  endtask

  task automatic idle(input logic wrr);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, wrr);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2;
    wr_ready = 1'b1;
    model_reset();
    #12;
    check_eq("rst_req0_ready", req0_ready, 1'b0);
    check_eq("rst_req1_ready", req1_ready, 1'b0);
    check_eq("rst_wr_en", wr_en, 1'b0);
    check_eq("rst_wr_addr", wr_addr, 5'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);
    check_eq("rst_zero_drop", zero_drop, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1'b1);

    // Both requesters held valid: strict alternation starting from the reset priority.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'd3, 32'hAAAA_AAAA, 1'b1, 5'd7, 32'h5555_5555, 1'b1);
      check_eq("alt_win", last_win, i % 2);
      check_eq("alt_addr", wr_addr, (i % 2) ? 5'd7 : 5'd3);
      check_eq("alt_en", wr_en, 1'b1);
    end
    idle(1'b1);

    cycle(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b1);
    check_eq("single_win", last_win, 0);
    check_eq("single_en", wr_en, 1'b1);
    check_eq("single_addr", wr_addr, 5'd5);
    check_eq("single_data", wr_data, 32'h0000_1234);

    // Port stalled with the load path waiting, then released with no bubble.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0BAD_F00D, 1'b0);
      check_eq("hold_win", last_win, -1);
      check_eq("hold_addr", wr_addr, 5'd5);
      check_eq("hold_data", wr_data, 32'h0000_1234);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0BAD_F00D, 1'b1);
    check_eq("release_win", last_win, 1);
    check_eq("release_en", wr_en, 1'b1);
    check_eq("release_addr", wr_addr, 5'd9);

    // Hand priority to the load path, then drop its write to register 0.
    cycle(1'b1, 5'd4, 32'h4444_4444, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1);
    check_eq("drop_win", last_win, 1);
    check_eq("drop_pulse", zero_drop, 1'b1);
    check_eq("drop_en", wr_en, 1'b0);
    idle(1'b1);
    check_eq("drop_once", zero_drop, 1'b0);
    cycle(1'b1, 5'd3, 32'h3, 1'b1, 5'd7, 32'h7, 1'b1);
    check_eq("drop_prio", last_win, 0);

    // Asynchronous reset while a write is stalled on the port.
    cycle(1'b1, 5'd6, 32'h6666_0000, 1'b0, 5'd0, 32'd0, 1'b1);
    req0_valid = 1'b0; req1_valid = 1'b1; wr_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_wr_en", wr_en, 1'b0);
    check_eq("arst_req1_ready", req1_ready, 1'b0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1'b1);
    check_eq("arst_no_write", wr_en, 1'b0);
    cycle(1'b1, 5'd3, 32'h3, 1'b1, 5'd7, 32'h7, 1'b1);
    check_eq("arst_prio", last_win, 0);

    for (int i = 0; i < 600; i++) begin
      logic [4:0] a0, a1;
      a0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle(1'($urandom_range(0, 1)), a0, $urandom,
            1'($urandom_range(0, 1)), a1, $urandom,
            ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
